// File: rtl/asp_hostmem_rd_burst_splitter.sv
// Splits upstream host-memory read bursts into fragments that neither cross a
// page nor exceed the channel's maximum burst; read responses pass straight through.
module asp_hostmem_rd_burst_splitter #(
  parameter int ADDR_WIDTH         = 48,
  parameter int DATA_WIDTH         = 512,
  parameter int USER_WIDTH         = 8,
  parameter int IN_BURSTCNT_WIDTH  = 8,
  parameter int OUT_BURSTCNT_WIDTH = 6,
  parameter int MAX_OUT_BURST      = 32,
  parameter int PAGE_LINES_LOG2    = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_WIDTH-1:0]         s_address,
  input  logic [IN_BURSTCNT_WIDTH-1:0]  s_burstcount,
  input  logic [USER_WIDTH-1:0]         s_user,
  input  logic                          s_read,
  output logic                          s_waitrequest,
  output logic [DATA_WIDTH-1:0]         s_readdata,
  output logic                          s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]         m_address,
  output logic [OUT_BURSTCNT_WIDTH-1:0] m_burstcount,
  output logic [USER_WIDTH-1:0]         m_user,
  output logic                          m_read,
  input  logic                          m_waitrequest,
  input  logic [DATA_WIDTH-1:0]         m_readdata,
  input  logic                          m_readdatavalid,
  output logic [31:0]                   frag_count,
  output logic                          err_zero_burst
);

  localparam int PL   = PAGE_LINES_LOG2;
  localparam int LW_A = (IN_BURSTCNT_WIDTH > PL + 1) ? IN_BURSTCNT_WIDTH : PL + 1;
  localparam int LW_B = $clog2(MAX_OUT_BURST) + 1;
  localparam int LW   = (LW_A > LW_B) ? LW_A : LW_B;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  // Fragment length is the smallest of what is left, the channel limit and the
  // distance to the next page boundary (never zero, even at offset 0).
  function automatic logic [LW-1:0] frag_len_f(input logic [PL-1:0]                addr_lo,
                                               input logic [IN_BURSTCNT_WIDTH-1:0] rem);
    logic [LW-1:0] to_page;
    logic [LW-1:0] rem_w;
    logic [LW-1:0] len;
    to_page = (LW'(1'b1) << PL) - LW'(addr_lo);
    rem_w   = LW'(rem);
    len     = (rem_w < LW'(MAX_OUT_BURST)) ? rem_w : LW'(MAX_OUT_BURST);
    len     = (to_page < len) ? to_page : len;
    return len;
  endfunction

  state_t                          state_r;
  logic [ADDR_WIDTH-1:0]           cur_addr_r;
  logic [IN_BURSTCNT_WIDTH-1:0]    remaining_r;
  logic [USER_WIDTH-1:0]           user_r;
  logic [OUT_BURSTCNT_WIDTH-1:0]   burst_r;
  logic                            m_read_r;
  logic                            s_wait_r;
  logic [31:0]                     frag_count_r;
  logic                            err_r;

  logic [LW-1:0]                   first_len_s;
  logic [LW-1:0]                   cur_len_s;
  logic [ADDR_WIDTH-1:0]           next_addr_s;
  logic [IN_BURSTCNT_WIDTH-1:0]    next_rem_s;
  logic [LW-1:0]                   next_len_s;
  logic                            last_s;

  // Lengths for the first fragment of a new burst and for the fragment after the current one.
  always_comb begin
    first_len_s = frag_len_f(s_address[PL-1:0], s_burstcount);
    cur_len_s   = LW'(burst_r);
    next_addr_s = cur_addr_r + ADDR_WIDTH'(cur_len_s);
    next_rem_s  = remaining_r - IN_BURSTCNT_WIDTH'(cur_len_s);
    next_len_s  = frag_len_f(next_addr_s[PL-1:0], next_rem_s);
    last_s      = (LW'(remaining_r) == cur_len_s);
  end

  // Splitter FSM with registered request outputs, fragment counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= '0;
      remaining_r  <= '0;
      user_r       <= '0;
      burst_r      <= '0;
      m_read_r     <= 1'b0;
      s_wait_r     <= 1'b0;
      frag_count_r <= 32'd0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (s_read) begin
            if (s_burstcount != '0) begin
              state_r     <= ST_ISSUE;
              cur_addr_r  <= s_address;
              remaining_r <= s_burstcount;
              user_r      <= s_user;
              burst_r     <= OUT_BURSTCNT_WIDTH'(first_len_s);
              m_read_r    <= 1'b1;
              s_wait_r    <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end else begin
            s_wait_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!m_waitrequest) begin
            if (frag_count_r != 32'hFFFF_FFFF) begin
              frag_count_r <= frag_count_r + 32'd1;
            end else begin
              frag_count_r <= frag_count_r;
            end
            if (last_s) begin
              state_r  <= ST_IDLE;
              m_read_r <= 1'b0;
              s_wait_r <= 1'b0;
            end else begin
              cur_addr_r  <= next_addr_s;
              remaining_r <= next_rem_s;
              burst_r     <= OUT_BURSTCNT_WIDTH'(next_len_s);
            end
          end else begin
            m_read_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          m_read_r <= 1'b0;
          s_wait_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_waitrequest   = s_wait_r;
  assign m_read          = m_read_r;
  assign m_address       = cur_addr_r;
  assign m_burstcount    = burst_r;
  assign m_user          = user_r;
  assign frag_count      = frag_count_r;
  assign err_zero_burst  = err_r;
  assign s_readdata      = m_readdata;
  assign s_readdatavalid = m_readdatavalid;

endmodule

// File: tb/tb_asp_hostmem_rd_burst_splitter.sv
// Randomized and directed bench for the read burst splitter, checked every cycle
// against a queue-based fragment model computed from the page/size rules.
module tb_asp_hostmem_rd_burst_splitter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [47:0]  s_address;
  logic [7:0]   s_burstcount;
  logic [7:0]   s_user;
  logic         s_read;
  logic         s_waitrequest;
  logic [511:0] s_readdata;
  logic         s_readdatavalid;
  logic [47:0]  m_address;
  logic [5:0]   m_burstcount;
  logic [7:0]   m_user;
  logic         m_read;
  logic         m_waitrequest;
  logic [511:0] m_readdata;
  logic         m_readdatavalid;
  logic [31:0]  frag_count;
  logic         err_zero_burst;

  asp_hostmem_rd_burst_splitter dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_user(s_user), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_user(m_user), .m_read(m_read),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .frag_count(frag_count), .err_zero_burst(err_zero_burst)
  );

  always #5 clk = ~clk;

  typedef struct { logic [47:0] addr; int len; logic [7:0] user; } frag_t;
  typedef struct { logic [47:0] addr; int len; int cyc; } log_t;

  frag_t exp_q[$];
  frag_t pin_q[$];
  log_t  log_q[$];
  int    total = 0;
  int    passed = 0;
  int    cyc = 0;
  int    exp_fc = 0;
  bit    exp_err = 1'b0;
  bit    mon_en = 1'b0;
  bit    rand_stall = 1'b0;
  int    stall_left = 0;
  logic [47:0] stall_addr = 48'h0;
  int    wr_cnt = 0;

  function automatic void chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Fragment list from the rules: min(remaining, 32, lines left in the 64-line page).
  function automatic void model_split(input logic [47:0] a, input int bc, input logic [7:0] u,
                                      input bit to_pin);
    int rem;
    int len;
    int to_page;
    frag_t f;
    rem = bc;
    while (rem > 0) begin
      to_page = 64 - int'(a % 48'd64);
      len = rem;
      if (len > 32) len = 32;
      if (len > to_page) len = to_page;
      f.addr = a; f.len = len; f.user = u;
      if (to_pin) pin_q.push_back(f);
      else exp_q.push_back(f);
      a = a + 48'(len);
      rem -= len;
    end
  endfunction

  // Per-cycle compare and model update, sampled on the falling edge.
  initial begin
    bit busy;
    bit prev_stall;
    logic [47:0] prev_addr;
    logic [5:0]  prev_len;
    logic [7:0]  prev_user;
    prev_stall = 1'b0; prev_addr = '0; prev_len = '0; prev_user = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && mon_en) begin
        busy = (exp_q.size() != 0);
        chk("m_read", m_read, busy);
        chk("s_waitrequest", s_waitrequest, busy);
        if (busy && m_read) begin
          chk("m_address", m_address, exp_q[0].addr);
          chk("m_burstcount", m_burstcount, exp_q[0].len);
          chk("m_user", m_user, exp_q[0].user);
        end
        chk("frag_count", frag_count, exp_fc);
        chk("err_zero_burst", err_zero_burst, exp_err);
        chk("s_readdata", s_readdata, m_readdata);
        chk("s_readdatavalid", s_readdatavalid, m_readdatavalid);
        if (prev_stall) begin
          chk("hold_address", m_address, prev_addr);
          chk("hold_burstcount", m_burstcount, prev_len);
          chk("hold_user", m_user, prev_user);
        end
        prev_stall = m_read && m_waitrequest;
        prev_addr = m_address; prev_len = m_burstcount; prev_user = m_user;
        if (s_waitrequest) wr_cnt++;
        if (m_read && !m_waitrequest && busy) begin
          log_q.push_back('{addr: m_address, len: int'(m_burstcount), cyc: cyc});
          void'(exp_q.pop_front());
          exp_fc++;
        end
        if (s_read && !busy) begin
          if (s_burstcount == 8'd0) exp_err = 1'b1;
          else model_split(s_address, int'(s_burstcount), s_user, 1'b0);
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) m_readdata[i*32 +: 32] = $urandom;
    m_readdatavalid = 1'($urandom_range(0, 1));
    if (stall_left > 0 && m_read && m_address == stall_addr) begin
      m_waitrequest = 1'b1;
      stall_left--;
    end else if (rand_stall) begin
      m_waitrequest = ($urandom_range(0, 3) == 0);
    end else begin
      m_waitrequest = 1'b0;
    end
  endtask

  task automatic req(input logic [47:0] a, input int bc, input logic [7:0] u);
    bit ok;
    ok = 1'b0;
    s_address = a; s_burstcount = 8'(bc); s_user = u; s_read = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = !s_waitrequest;
      tick();
    end
    s_read = 1'b0;
    chk("req_accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      if (exp_q.size() == 0 && !s_waitrequest) done = 1'b1;
      else tick();
    end
    chk("drain_timeout", done, 1'b1);
    tick();
  endtask

  task automatic chk_frag(input int idx, input logic [47:0] a, input int len);
    if (idx < log_q.size()) begin
      chk("frag_addr", log_q[idx].addr, a);
      chk("frag_len", log_q[idx].len, len);
    end else begin
      chk("frag_missing", idx, log_q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0; s_address = '0; s_burstcount = '0; s_user = '0; s_read = 1'b0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

    model_split(48'h3E, 40, 8'h00, 1'b1);
    chk("pin_count", pin_q.size(), 3);
    if (pin_q.size() == 3) begin
      chk("pin0", {pin_q[0].addr, 32'(pin_q[0].len)}, {48'h3E, 32'd2});
      chk("pin1", {pin_q[1].addr, 32'(pin_q[1].len)}, {48'h40, 32'd32});
      chk("pin2", {pin_q[2].addr, 32'(pin_q[2].len)}, {48'h60, 32'd6});
    end

    repeat (3) @(posedge clk);
    chk("rst_m_read", m_read, 1'b0);
    chk("rst_s_waitrequest", s_waitrequest, 1'b0);
    chk("rst_frag_count", frag_count, 32'd0);
    chk("rst_err", err_zero_burst, 1'b0);
    chk("rst_m_fields", {m_address, m_burstcount, m_user}, 62'd0);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single line at the last offset of a page.
    log_q.delete(); wr_cnt = 0;
    req(48'h3F, 1, 8'h11);
    wait_idle();
    chk("t1_frags", log_q.size(), 1);
    chk_frag(0, 48'h3F, 1);
    chk("t1_wr_cycles", wr_cnt, 1);
    chk("t1_frag_count", frag_count, 32'd1);

    // Page split with back-to-back fragments.
    log_q.delete();
    req(48'h3E, 40, 8'h22);
    wait_idle();
    chk("t2_frags", log_q.size(), 3);
    chk_frag(0, 48'h3E, 2); chk_frag(1, 48'h40, 32); chk_frag(2, 48'h60, 6);
    if (log_q.size() == 3) begin
      chk("t2_b2b_1", log_q[1].cyc, log_q[0].cyc + 1);
      chk("t2_b2b_2", log_q[2].cyc, log_q[1].cyc + 1);
    end

    // Aligned 64 lines: size split only.
    log_q.delete();
    req(48'h0, 64, 8'h33);
    wait_idle();
    chk("t3_frags", log_q.size(), 2);
    chk_frag(0, 48'h0, 32); chk_frag(1, 48'h20, 32);

    // Five-cycle stall on the second fragment.
    log_q.delete(); stall_addr = 48'h40; stall_left = 5;
    req(48'h3E, 40, 8'h44);
    wait_idle();
    chk("t4_frags", log_q.size(), 3);
    chk_frag(1, 48'h40, 32);
    if (log_q.size() == 3) begin
      chk("t4_stall_len", log_q[1].cyc - log_q[0].cyc, 6);
      chk("t4_after_stall", log_q[2].cyc, log_q[1].cyc + 1);
    end

    // Zero-length request, then a legal one.
    log_q.delete();
    req(48'h55, 0, 8'h55);
    tick(); tick();
    chk("t5_no_frag", log_q.size(), 0);
    chk("t5_err", err_zero_burst, 1'b1);
    req(48'h80, 3, 8'h56);
    wait_idle();
    chk_frag(0, 48'h80, 3);
    chk("t5_err_sticky", err_zero_burst, 1'b1);

    // Address wrap at the top of the space.
    log_q.delete();
    req(48'hFFFF_FFFF_FFFE, 4, 8'h66);
    wait_idle();
    chk("t6_frags", log_q.size(), 2);
    chk_frag(0, 48'hFFFF_FFFF_FFFE, 2); chk_frag(1, 48'h0, 2);

    // Asynchronous reset during the second fragment.
    req(48'h3E, 40, 8'h77);
    tick();
    chk("t7_second_frag", m_address, 48'h40);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_rst_m_read", m_read, 1'b0);
    chk("t7_rst_wait", s_waitrequest, 1'b0);
    chk("t7_rst_fields", {m_address, m_burstcount, m_user}, 62'd0);
    chk("t7_rst_count", frag_count, 32'd0);
    chk("t7_rst_err", err_zero_burst, 1'b0);
    exp_q.delete(); log_q.delete(); exp_fc = 0; exp_err = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    req(48'h100, 4, 8'h88);
    wait_idle();
    chk("t7_frags", log_q.size(), 1);
    chk_frag(0, 48'h100, 4);

    // Randomized traffic with random downstream stalls.
    rand_stall = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [47:0] a;
      int bc;
      a[31:0]  = $urandom;
      a[47:32] = 16'($urandom);
      bc = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 128));
      req(a, bc, 8'($urandom));
    end
    wait_idle();
    rand_stall = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
